cp0_exc_ctrl: RTL

//  Exception/ERET sequencer and write-port arbiter for the CP0 register file.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_int_detect.sv | 14 +
 rtl/cp0_exc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, ExcCodes, Status bit indices and sequencer states.
// The CP0_BADVADDR_EN macro adds the BadVAddr write state.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
`ifdef CP0_BADVADDR_EN
    S_W_BADV,
`endif
    S_W_STATUS,
    S_E_STATUS,
    S_REDIRECT
  } cp0_state_e;

  // A nested exception (EXL already set) must not overwrite the original BD flag.
  function automatic logic [31:0] cause_merge(input logic [31:0] cause,
                                              input logic [4:0]  code,
                                              input logic        bd,
                                              input logic        keep_bd);
    logic [31:0] c;
    c      = cause;
    c[6:2] = code;
    if (!keep_bd) c[31] = bd;
    return c;
  endfunction

endpackage

// File: rtl/cp0_int_detect.sv
// Interrupt pending detection: enabled, not at exception level, and any unmasked line raised.
module cp0_int_detect
  import cp0_pkg::*;
(
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [7:0] im_i,
  input  logic [7:0] ip_i,
  output logic       int_pending_o
);

  assign int_pending_o = ie_i & ~exl_i & (|(im_i & ip_i));

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer and CP0 write-port arbiter; merges MTC0 with multi-register updates.
// Defining CP0_BADVADDR_EN adds a BadVAddr write for AdEL/AdES.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        cp0_exc_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  cp0_state_e  state_q, state_d;
  logic [4:0]  code_q;
  logic        bd_q;
  logic        exl_old_q;
  logic        eret_q;
  // Holds the EPC value to write on an exception, or the ERET return target.
  logic [31:0] pc_q;
  logic        int_pending;
  logic        int_req;
  logic        exc_take;
  logic        idle;

  cp0_int_detect u_int_detect (
    .ie_i          (status_i[STATUS_IE]),
    .exl_i         (status_i[STATUS_EXL]),
    .im_i          (status_i[15:8]),
    .ip_i          (cause_i[15:8]),
    .int_pending_o (int_pending)
  );

  assign idle     = (state_q == S_IDLE);
  assign int_req  = int_pending & mem_valid_i;
  assign exc_take = exc_valid_i | int_req;
  assign stall_o  = ~idle;

`ifdef CP0_BADVADDR_EN
  logic [31:0] badv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badv_q <= 32'h0;
    end else if (idle && exc_valid_i) begin
      badv_q <= exc_badvaddr_i;
    end
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^exc_badvaddr_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= 5'd0;
      bd_q      <= 1'b0;
      exl_old_q <= 1'b0;
      eret_q    <= 1'b0;
      pc_q      <= 32'h0;
    end else begin
      state_q <= state_d;
      if (idle && exc_take) begin
        code_q    <= exc_valid_i ? exc_code_i : EXC_INT;
        bd_q      <= exc_bd_i;
        exl_old_q <= status_i[STATUS_EXL];
        eret_q    <= 1'b0;
        pc_q      <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end else if (idle && eret_i) begin
        eret_q <= 1'b1;
        pc_q   <= epc_i;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cp0_we_o      = 1'b0;
    cp0_waddr_o   = 5'd0;
    cp0_wdata_o   = 32'h0;
    cp0_exc_o     = 1'b0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (exc_take) begin
          state_d = S_W_EPC;
        end else if (eret_i) begin
          state_d = S_E_STATUS;
        end else if (mtc0_we_i && !rst) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = mtc0_addr_i;
          cp0_wdata_o = mtc0_data_i;
        end
      end
      S_W_EPC: begin
        cp0_we_o    = ~exl_old_q;
        cp0_exc_o   = ~exl_old_q;
        cp0_waddr_o = CP0_EPC;
        cp0_wdata_o = pc_q;
        flush_o     = 1'b1;
        state_d     = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        cp0_we_o    = 1'b1;
        cp0_exc_o   = 1'b1;
        cp0_waddr_o = CP0_CAUSE;
        cp0_wdata_o = cause_merge(cause_i, code_q, bd_q, exl_old_q);
        state_d     = S_W_STATUS;
`ifdef CP0_BADVADDR_EN
        if (code_q == EXC_ADEL || code_q == EXC_ADES) state_d = S_W_BADV;
`endif
      end
`ifdef CP0_BADVADDR_EN
      S_W_BADV: begin
        cp0_we_o    = 1'b1;
        cp0_exc_o   = 1'b1;
        cp0_waddr_o = CP0_BADVADDR;
        cp0_wdata_o = badv_q;
        state_d     = S_W_STATUS;
      end
`endif
      S_W_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_exc_o   = 1'b1;
        cp0_waddr_o = CP0_STATUS;
        cp0_wdata_o = status_i | (32'h1 << STATUS_EXL);
        state_d     = S_REDIRECT;
      end
      S_E_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_exc_o   = 1'b1;
        cp0_waddr_o = CP0_STATUS;
        cp0_wdata_o = status_i & ~(32'h1 << STATUS_EXL);
        flush_o     = 1'b1;
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = eret_q ? pc_q : EXC_VECTOR;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
